// File: rtl/error_delta_sequencer.sv
// Streams one signed error term per output digit (weight minus 8*label bit) over a
// valid/ready handshake, accumulating a saturating sum of magnitudes.
module error_delta_sequencer #(
  parameter int NUM_DIGITS = 10,
  parameter int WEIGHT_W   = 4,
  parameter int DEAD_ZONE  = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    delta_en,
  input  logic [0:NUM_DIGITS-1]                   expected_label,
  input  logic [0:NUM_DIGITS-1][WEIGHT_W-1:0]     digit_weights,
  input  logic                                    delta_ready,
  output logic                                    delta_valid,
  output logic [3:0]                              delta_index,
  output logic signed [WEIGHT_W:0]                delta_value,
  output logic                                    delta_last,
  output logic                                    busy,
  output logic                                    label_error,
  output logic [7:0]                              error_sum,
  output logic                                    sequence_complete
);

  localparam int ONES_W = $clog2(NUM_DIGITS + 1);
  localparam logic [3:0] LAST_INDEX = 4'(NUM_DIGITS - 1);
  localparam logic signed [WEIGHT_W:0] TARGET = (WEIGHT_W + 1)'(8);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t                                state_reg;
  logic [0:NUM_DIGITS-1]                 label_reg;
  logic [0:NUM_DIGITS-1][WEIGHT_W-1:0]   weights_reg;
  logic [3:0]                            index_reg;
  logic                                  valid_reg;
  logic                                  busy_reg;
  logic                                  label_error_reg;
  logic [7:0]                            error_sum_reg;
  logic                                  complete_reg;

  logic signed [WEIGHT_W:0] digit_delta [NUM_DIGITS];
  logic [WEIGHT_W:0]        digit_mag   [NUM_DIGITS];
  logic [ONES_W-1:0]        label_ones;
  logic [8:0]               sum_next;

  // Per-digit error terms are computed from the snapshot only, so the live input
  // buses cannot disturb a sequence in flight.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic signed [WEIGHT_W:0] raw;
      logic signed [WEIGHT_W:0] target;
      logic [WEIGHT_W:0]        raw_mag;
      logic                     in_dead_zone;
      assign target       = label_reg[gi] ? TARGET : '0;
      assign raw          = $signed({1'b0, weights_reg[gi]}) - target;
      assign raw_mag      = raw[WEIGHT_W] ? (WEIGHT_W + 1)'(-raw) : (WEIGHT_W + 1)'(raw);
      assign in_dead_zone = (int'(raw_mag) <= DEAD_ZONE);
      assign digit_delta[gi] = in_dead_zone ? '0 : raw;
      assign digit_mag[gi]   = in_dead_zone ? '0 : raw_mag;
    end
  endgenerate

  always_comb begin
    label_ones = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      label_ones = label_ones + ONES_W'(expected_label[i]);
    end
  end

  assign sum_next = {1'b0, error_sum_reg} + 9'(digit_mag[index_reg]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      label_reg       <= '0;
      weights_reg     <= '0;
      index_reg       <= '0;
      valid_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      label_error_reg <= 1'b0;
      error_sum_reg   <= '0;
      complete_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (delta_en) begin
            label_reg       <= expected_label;
            weights_reg     <= digit_weights;
            label_error_reg <= (label_ones != ONES_W'(1));
            error_sum_reg   <= '0;
            index_reg       <= '0;
            valid_reg       <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= EMIT;
          end
        end
        EMIT: begin
          if (delta_ready) begin
            error_sum_reg <= sum_next[8] ? 8'hFF : sum_next[7:0];
            if (index_reg == LAST_INDEX) begin
              valid_reg    <= 1'b0;
              complete_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              index_reg <= index_reg + 4'd1;
            end
          end
        end
        DONE: begin
          complete_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign delta_valid       = valid_reg;
  assign delta_index       = index_reg;
  assign delta_value       = valid_reg ? digit_delta[index_reg] : '0;
  assign delta_last        = valid_reg && (index_reg == LAST_INDEX);
  assign busy              = busy_reg;
  assign label_error       = label_error_reg;
  assign error_sum         = error_sum_reg;
  assign sequence_complete = complete_reg;

endmodule

// File: tb/tb_error_delta_sequencer.sv
// Directed bench for error_delta_sequencer; a second instance is built with DEAD_ZONE=2.
module tb_error_delta_sequencer;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic             rst, delta_en, delta_ready, sel;
  logic [0:9]       expected_label;
  logic [0:9][3:0]  digit_weights;

  logic             a_valid, a_last, a_busy, a_lerr, a_comp;
  logic [3:0]       a_index;
  logic signed [4:0] a_value;
  logic [7:0]       a_sum;
  logic             b_valid, b_last, b_busy, b_lerr, b_comp;
  logic [3:0]       b_index;
  logic signed [4:0] b_value;
  logic [7:0]       b_sum;

  logic             mon_valid, mon_last, mon_busy, mon_lerr, mon_comp;
  logic [3:0]       mon_index;
  logic signed [4:0] mon_value;
  logic [7:0]       mon_sum;

  error_delta_sequencer #(.NUM_DIGITS(10), .WEIGHT_W(4), .DEAD_ZONE(0)) dut (
    .clk(tb_clk), .rst(rst), .delta_en(delta_en & ~sel),
    .expected_label(expected_label), .digit_weights(digit_weights),
    .delta_ready(delta_ready), .delta_valid(a_valid), .delta_index(a_index),
    .delta_value(a_value), .delta_last(a_last), .busy(a_busy),
    .label_error(a_lerr), .error_sum(a_sum), .sequence_complete(a_comp)
  );

  error_delta_sequencer #(.NUM_DIGITS(10), .WEIGHT_W(4), .DEAD_ZONE(2)) dut_dz (
    .clk(tb_clk), .rst(rst), .delta_en(delta_en & sel),
    .expected_label(expected_label), .digit_weights(digit_weights),
    .delta_ready(delta_ready), .delta_valid(b_valid), .delta_index(b_index),
    .delta_value(b_value), .delta_last(b_last), .busy(b_busy),
    .label_error(b_lerr), .error_sum(b_sum), .sequence_complete(b_comp)
  );

  assign mon_valid = sel ? b_valid : a_valid;
  assign mon_last  = sel ? b_last  : a_last;
  assign mon_busy  = sel ? b_busy  : a_busy;
  assign mon_lerr  = sel ? b_lerr  : a_lerr;
  assign mon_comp  = sel ? b_comp  : a_comp;
  assign mon_index = sel ? b_index : a_index;
  assign mon_value = sel ? b_value : a_value;
  assign mon_sum   = sel ? b_sum   : a_sum;

  int checks = 0;
  int failures = 0;

  // Results gathered by collect() for the calling test to judge
  int got_val [10];
  int got_idx [10];
  int hs_cnt, comp_cnt, last_bad, stall_seen, stall_changes, timed_out;

  task automatic start(input logic [0:9] label, input logic [0:9][3:0] w);
    expected_label = label;
    digit_weights  = w;
    delta_en       = 1'b1;
    @(negedge tb_clk);
    delta_en       = 1'b0;
  endtask

  // Runs the handshake until busy drops; optional stall, delta_en poking, input scrambling.
  task automatic collect(input int stall_idx, input int stall_cycles,
                         input bit poke_en, input bit scramble);
    logic [3:0]        s_idx;
    logic signed [4:0] s_val;
    logic [7:0]        s_sum;
    bit                done;
    hs_cnt = 0; comp_cnt = 0; last_bad = 0; stall_seen = 0; stall_changes = 0;
    timed_out = 0; done = 0;
    s_idx = '0; s_val = '0; s_sum = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (!mon_busy) begin
        delta_en = 1'b0;
        done = 1;
      end else begin
        if (mon_comp) comp_cnt++;
        delta_ready = 1'b1;
        if (mon_valid && int'(mon_index) == stall_idx && stall_seen < stall_cycles) begin
          if (stall_seen == 0) begin
            s_idx = mon_index; s_val = mon_value; s_sum = mon_sum;
          end else if (mon_index !== s_idx || mon_value !== s_val || mon_sum !== s_sum) begin
            stall_changes++;
          end
          delta_ready = 1'b0;
          stall_seen++;
        end
        if (mon_valid && delta_ready) begin
          if (hs_cnt < 10) begin
            got_val[hs_cnt] = int'(mon_value);
            got_idx[hs_cnt] = int'(mon_index);
          end
          if (mon_last !== (mon_index == 4'd9)) last_bad++;
          $display("  handshake idx=%0d value=%0d last=%0b sum=%0d",
                   mon_index, mon_value, mon_last, mon_sum);
          hs_cnt++;
        end
        delta_en = poke_en;
        if (scramble) begin
          expected_label = 10'($urandom);
          digit_weights  = 40'({$urandom, $urandom});
        end
        @(negedge tb_clk);
      end
    end
    if (!done) timed_out = 1;
    delta_en = 1'b0;
    delta_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge tb_clk);
    checks++;
    if ({a_valid, a_index, a_value, a_last, a_busy, a_lerr, a_sum, a_comp} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {a_valid, a_index, a_value, a_last, a_busy, a_lerr, a_sum, a_comp});
    end
    rst = 1'b0;
    @(negedge tb_clk);
  endtask

  task automatic check_seq(input string name, input int exp_val [10], input int exp_sum,
                           input logic exp_lerr);
    checks++;
    if (timed_out != 0 || hs_cnt !== 10) begin
      failures++;
      $display("FAIL %s_handshakes: got %0d (timeout=%0d) required 10", name, hs_cnt, timed_out);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_val[i] !== exp_val[i] || got_idx[i] !== i) begin
        failures++;
        $display("FAIL %s_delta[%0d]: got idx=%0d val=%0d required idx=%0d val=%0d",
                 name, i, got_idx[i], got_val[i], i, exp_val[i]);
      end
    end
    checks++;
    if (mon_sum !== 8'(exp_sum)) begin
      failures++;
      $display("FAIL %s_error_sum: got %0d required %0d", name, mon_sum, exp_sum);
    end
    checks++;
    if (mon_lerr !== exp_lerr) begin
      failures++;
      $display("FAIL %s_label_error: got %0b required %0b", name, mon_lerr, exp_lerr);
    end
    checks++;
    if (comp_cnt !== 1) begin
      failures++;
      $display("FAIL %s_complete_pulses: got %0d required 1", name, comp_cnt);
    end
    checks++;
    if (last_bad !== 0) begin
      failures++;
      $display("FAIL %s_delta_last: got %0d bad cycles required 0", name, last_bad);
    end
  endtask

  task automatic test_digit3();
    int exp_val [10] = '{2, 2, 2, -1, 2, 2, 2, 2, 2, 2};
    start(10'b0001000000, {4'd2, 4'd2, 4'd2, 4'd7, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2});
    checks++;
    if (mon_valid !== 1'b1 || mon_busy !== 1'b1 || mon_index !== 4'd0) begin
      failures++;
      $display("FAIL start_latency: got valid=%0b busy=%0b idx=%0d required 1 1 0",
               mon_valid, mon_busy, mon_index);
    end
    collect(-1, 0, 1'b0, 1'b0);
    check_seq("digit3", exp_val, 19, 1'b0);
  endtask

  task automatic test_digit0_extremes();
    int exp_val [10] = '{-8, 15, 15, 15, 15, 15, 15, 15, 15, 15};
    start(10'b1000000000, {4'd0, {9{4'd15}}});
    collect(-1, 0, 1'b0, 1'b0);
    check_seq("digit0", exp_val, 143, 1'b0);
  endtask

  task automatic test_backpressure();
    int exp_val [10] = '{1, 3, 5, 7, 9, 11, 5, 15, 0, 8};
    start(10'b0000001000, {4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd0, 4'd8});
    collect(4, 3, 1'b0, 1'b1);
    check_seq("backpressure", exp_val, 64, 1'b0);
    checks++;
    if (stall_seen !== 3 || stall_changes !== 0) begin
      failures++;
      $display("FAIL stall_hold: got stalls=%0d changes=%0d required 3 0",
               stall_seen, stall_changes);
    end
  endtask

  task automatic test_back_to_back_en();
    int exp_val [10] = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 0};
    start(10'b0000000001, {10{4'd8}});
    collect(-1, 0, 1'b1, 1'b0);
    check_seq("en_ignored", exp_val, 72, 1'b0);
    repeat (3) @(negedge tb_clk);
    checks++;
    if (mon_busy !== 1'b0 || mon_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_restart: got busy=%0b valid=%0b required 0 0", mon_busy, mon_valid);
    end
  endtask

  task automatic test_mid_reset();
    int comps;
    int exp_val [10] = '{1, 3, 1, 1, 1, 1, 1, 1, 1, 1};
    start(10'b1100000000, {10{4'd4}});
    delta_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && mon_index != 4'd5; cyc++) @(negedge tb_clk);
    checks++;
    if (mon_index !== 4'd5 || mon_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_index5: got idx=%0d valid=%0b required 5 1", mon_index, mon_valid);
    end
    rst = 1'b1;
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    delta_ready = 1'b0;
    checks++;
    if ({mon_valid, mon_busy, mon_sum, mon_lerr, mon_index, mon_comp} !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_clear: got valid=%0b busy=%0b sum=%0d lerr=%0b idx=%0d required all 0",
               mon_valid, mon_busy, mon_sum, mon_lerr, mon_index);
    end
    comps = 0;
    repeat (12) begin
      if (mon_comp || mon_busy) comps++;
      @(negedge tb_clk);
    end
    checks++;
    if (comps !== 0) begin
      failures++;
      $display("FAIL mid_reset_quiet: got %0d active cycles required 0", comps);
    end
    start(10'b0100000000, {4'd1, 4'd11, {8{4'd1}}});
    checks++;
    if (mon_valid !== 1'b1 || mon_index !== 4'd0 || mon_value !== 5'sd1) begin
      failures++;
      $display("FAIL restart_index0: got valid=%0b idx=%0d val=%0d required 1 0 1",
               mon_valid, mon_index, mon_value);
    end
    collect(-1, 0, 1'b0, 1'b0);
    check_seq("restart", exp_val, 12, 1'b0);
  endtask

  task automatic test_dead_zone();
    int exp_raw [10] = '{2, 5, 0, 15, 1, 3, 7, 9, 2, 4};
    int exp_dz  [10] = '{0, 5, 0, 15, 0, 3, 7, 9, 0, 4};
    logic [0:9][3:0] w;
    w = {4'd2, 4'd5, 4'd0, 4'd15, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4};
    sel = 1'b0;
    start(10'b0000000000, w);
    collect(-1, 0, 1'b0, 1'b0);
    check_seq("no_label", exp_raw, 48, 1'b1);
    sel = 1'b1;
    start(10'b0000000000, w);
    collect(-1, 0, 1'b0, 1'b0);
    check_seq("dead_zone", exp_dz, 43, 1'b1);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; delta_en = 1'b0; delta_ready = 1'b1; sel = 1'b0;
    expected_label = '0; digit_weights = '0;
    @(negedge tb_clk);
    test_reset();
    test_digit3();
    test_digit0_extremes();
    test_backpressure();
    test_back_to_back_en();
    test_mid_reset();
    test_dead_zone();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
